// File: rtl/rr_stream_mux.sv
// rr_stream_mux
// Registered N-channel stream multiplexer with valid/ready handshakes.
// One input channel per cycle is granted, either by an explicit index
// (fixed mode) or by a round-robin scan that starts after the channel
// served most recently. The granted beat is captured in a single output
// register that supports full 1 beat/cycle throughput and holds under
// backpressure. in_ready is combinational; in_data never reaches an
// output without passing through the register.

module rr_stream_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Selection mode as a named type so the grant mux reads clearly.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    mode_e mode_sel;
    assign mode_sel = mode_e'(mode);

    // ------------------------------------------------------------------
    // State: output register and the last-served channel pointer.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] last_q,      last_d;

    // ------------------------------------------------------------------
    // Grant path signals.
    // ------------------------------------------------------------------
    logic             load_ok;      // output register can accept a beat
    logic             fixed_valid;  // sel is in range and that channel is valid
    logic             rr_valid;     // round-robin scan found a valid channel
    logic [SEL_W-1:0] rr_idx;       // winner of the round-robin scan
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             in_xfer;      // a beat moves from an input into the register
    logic             out_xfer;     // the consumer takes the registered beat

    // The register may load when it is empty or is being drained this cycle.
    assign load_ok  = !out_valid_q || out_ready;
    assign out_xfer = out_valid_q && out_ready;

    // Fixed-mode grant: sel must name an existing channel that is valid.
    // Comparing against each index avoids any out-of-range part-select
    // when CHANNELS is not a power of two.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a value unassigned and no latch is built.
        fixed_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) begin
                fixed_valid = 1'b1;
            end
        end
    end

    // Round-robin scan: candidates last+1, last+2, ... wrapping, with last
    // itself examined at the end; the first valid candidate wins.
    always_comb begin : rr_scan
        logic [SEL_W:0] cand;
        rr_valid = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            // last_q < CHANNELS and i <= CHANNELS, so one subtraction wraps.
            cand = {1'b0, last_q} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(CHANNELS)) begin
                cand = cand - (SEL_W+1)'(CHANNELS);
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (!rr_valid && cand == (SEL_W+1)'(k) && in_valid[k]) begin
                    rr_valid = 1'b1;
                    rr_idx   = SEL_W'(k);
                end
            end
        end
    end

    // Pick the active grant source for this cycle's mode.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = sel;
        case (mode_sel)
            MODE_RR: begin
                grant_valid = rr_valid;
                grant_idx   = rr_idx;
            end
            default: begin
                grant_valid = fixed_valid;
                grant_idx   = sel;
            end
        endcase
    end

    // Ready is one-hot on the granted channel, or all zero when nothing is
    // granted or the output register is full and stalled.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_valid && load_ok && grant_idx == SEL_W'(k)) begin
                in_ready[k] = 1'b1;
            end
        end
    end

    assign in_xfer = |(in_ready & in_valid);

    // Data mux for the granted channel; feeds only the register input.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for the output register and the last-served pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (in_xfer) begin
            // A load wins over a drain on the same edge: full throughput.
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            last_d      = grant_idx;
        end else if (out_xfer) begin
            // Data and channel keep their last values once the beat leaves.
            out_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset; reset overrides any transfer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the data register is reset here because its value after
            // reset is visible on out_data; it is a single word, not a memory.
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SEL_W'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux
// Directed bench for rr_stream_mux (WIDTH=4, CHANNELS=4). The stimulus
// process pushes each beat it expects into a scoreboard queue; a monitor
// pops and compares on every output handshake. Direct checks cover reset
// values, in_ready patterns, holding under backpressure and drain timing.

module tb_rr_stream_mux;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      mode = 1'b0;
    logic [SEL_W-1:0]          sel = '0;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid = '0;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready = 1'b0;

    // Channels 0..3 carry 1000, 0100, 0010, 0001.
    assign in_data = {4'b0001, 4'b0010, 4'b0100, 4'b1000};

    rr_stream_mux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] chan;
    } beat_t;

    beat_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Expected beat from channel c: one-hot data with the bit walking down.
    task automatic push(input int c);
        beat_t b;
        b.chan = 2'(c);
        case (c)
            0:       b.data = 4'b1000;
            1:       b.data = 4'b0100;
            2:       b.data = 4'b0010;
            default: b.data = 4'b0001;
        endcase
        sb_q.push_back(b);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Monitor: every output handshake must match the next expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got chan %0d data %b, expected no beat", out_chan, out_data);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", 32'(out_data), 32'(e.data));
                check("sb_chan", 32'(out_chan), 32'(e.chan));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Fixed mode, sel=1 then sel=2.
        do_reset();
        mode = 1'b0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
        push(1); push(1);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_chan",  32'(out_chan),  32'd0);
        check("fix_ready_sel1", 32'(in_ready), 32'b0010);
        cycle(); cycle();
        sel = 2'd2;
        push(2); push(2);
        @(negedge clk);
        check("fix_ready_sel2", 32'(in_ready), 32'b0100);
        cycle(); cycle();
        in_valid = 4'h0;
        @(negedge clk);
        check("fix_idle_ready", 32'(in_ready), 32'd0);
        cycle();
        @(negedge clk);
        check("fix_drain_valid", 32'(out_valid), 32'd0);
        check("fix_hold_data",   32'(out_data),  32'b0010);
        check("fix_hold_chan",   32'(out_chan),  32'd2);

        // 2. Round-robin, all channels valid: 0,1,2,3,0,1,2,3.
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(i % 4);
        @(negedge clk);
        check("rr_first_ready", 32'(in_ready), 32'b0001);
        repeat (8) cycle();
        in_valid = 4'h0;
        cycle();
        @(negedge clk);
        check("rr_drain_valid", 32'(out_valid), 32'd0);

        // 3. Round-robin, sparse valid 1010: 1,3,1,3.
        do_reset();
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        push(1); push(3); push(1); push(3);
        @(negedge clk);
        check("sparse_first_ready", 32'(in_ready), 32'b0010);
        repeat (4) cycle();
        in_valid = 4'h0;
        @(negedge clk);
        check("sparse_idle_ready", 32'(in_ready), 32'd0);
        cycle();
        @(negedge clk);
        check("sparse_drain_valid", 32'(out_valid), 32'd0);

        // 4. Backpressure for 3 cycles while holding channel 1.
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        push(0); push(1);
        repeat (2) cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(out_data),  32'b0100);
            check("bp_chan",  32'(out_chan),  32'd1);
            check("bp_ready", 32'(in_ready),  32'd0);
            cycle();
        end
        out_ready = 1'b1;
        push(2); push(3); push(0);
        @(negedge clk);
        check("bp_resume_ready", 32'(in_ready), 32'b0100);
        repeat (3) cycle();
        in_valid = 4'h0;
        cycle();
        @(negedge clk);
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // 5. Reset while a beat is stalled in the register.
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
        cycle();
        @(negedge clk);
        check("mid_loaded_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        push(0);
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_chan",  32'(out_chan),  32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'b0001);
        cycle();
        in_valid = 4'h0;
        cycle();
        @(negedge clk);
        check("mid_drain_valid", 32'(out_valid), 32'd0);

        // 6. Fixed sel=2 twice, then round-robin continues 3,0,1; then a
        //    fixed select of an invalid channel grants nothing.
        do_reset();
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        push(2); push(2);
        repeat (2) cycle();
        mode = 1'b1;
        push(3); push(0); push(1);
        @(negedge clk);
        check("sw_ready", 32'(in_ready), 32'b1000);
        repeat (3) cycle();
        mode = 1'b0; sel = 2'd3; in_valid = 4'b0111;
        @(negedge clk);
        check("sel3_ready_busy", 32'(in_ready), 32'd0);
        cycle();
        @(negedge clk);
        check("sel3_drain_valid", 32'(out_valid), 32'd0);
        check("sel3_ready_idle",  32'(in_ready),  32'd0);

        // Every expected beat must have been observed.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
